// File: rtl/adc_bcd_formatter.sv
// rtl/adc_bcd_formatter.sv - averages ADC samples and formats them as BCD display digits
// Sequential double-dabble conversion with leading-zero blanking and a fixed prefix digit.
module adc_bcd_formatter #(
  parameter int         AVG_LOG2    = 0,
  parameter logic [3:0] BLANK_CODE  = 4'd10,
  parameter logic [3:0] PREFIX_CODE = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sample,
  input  logic        sample_vld,
  output logic        busy,
  output logic [31:0] dsp_data,
  output logic        dsp_vld
);

  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {ACC, CONV, OUT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [19:0]     sr;
  logic [2:0]      iter;
  logic            take;
  logic            last;
  logic [AW-1:0]   sum;
  logic [7:0]      avg;
  logic [3:0]      dig_h;
  logic [3:0]      dig_t;
  logic [3:0]      dig_o;
  logic [31:0]     fmt_word;

  // One double-dabble iteration: correct every BCD nibble, then shift the whole register.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int i = 0; i < 3; i++) begin
      if (a[8 + 4*i +: 4] >= 4'd5)
        a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  assign last = (cnt == LAST);
  assign sum  = acc + AW'(sample);
  assign avg  = 8'(sum >> AVG_LOG2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ACC;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    take      = 1'b0;
    case (state)
      ACC: begin
        busy = 1'b0;
        take = sample_vld;
        if (take && last)
          state_nxt = CONV;
      end
      CONV: begin
        if (iter == 3'd7)
          state_nxt = OUT;
      end
      OUT: state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    dig_h    = sr[19:16];
    dig_t    = sr[15:12];
    dig_o    = sr[11:8];
    fmt_word = {PREFIX_CODE, {4{BLANK_CODE}},
                (dig_h != 4'd0) ? dig_h : BLANK_CODE,
                ((dig_h != 4'd0) || (dig_t != 4'd0)) ? dig_t : BLANK_CODE,
                dig_o};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      sr       <= '0;
      iter     <= '0;
      dsp_data <= {PREFIX_CODE, {7{BLANK_CODE}}};
      dsp_vld  <= 1'b0;
    end else begin
      dsp_vld <= 1'b0;
      case (state)
        ACC: begin
          if (take) begin
            if (last) begin
              acc  <= '0;
              cnt  <= '0;
              sr   <= {12'd0, avg};
              iter <= '0;
            end else begin
              acc <= sum;
              cnt <= cnt + CW'(1);
            end
          end
        end
        CONV: begin
          sr   <= dd_step(sr);
          iter <= iter + 3'd1;
        end
        OUT: begin
          dsp_data <= fmt_word;
          dsp_vld  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_bcd_formatter.sv
// tb/tb_adc_bcd_formatter.sv - directed and random checks of adc_bcd_formatter
// Instance a averages 1 sample, instance b averages 4.
module tb_adc_bcd_formatter;

  logic        clk;
  logic        rst;
  logic [7:0]  sample_a;
  logic        sample_vld_a;
  logic        busy_a;
  logic [31:0] dsp_data_a;
  logic        dsp_vld_a;
  logic [7:0]  sample_b;
  logic        sample_vld_b;
  logic        busy_b;
  logic [31:0] dsp_data_b;
  logic        dsp_vld_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic        early;
  int          hold_a, hold_b, due_a, due_b, acc_b, n_b;
  logic [31:0] exp_a, exp_b;
  logic [7:0]  s_a, s_b;
  logic [7:0]  vec_b [4];

  adc_bcd_formatter #(.AVG_LOG2(0)) u_a (
    .clk(clk), .rst(rst), .sample(sample_a), .sample_vld(sample_vld_a),
    .busy(busy_a), .dsp_data(dsp_data_a), .dsp_vld(dsp_vld_a)
  );

  adc_bcd_formatter #(.AVG_LOG2(2)) u_b (
    .clk(clk), .rst(rst), .sample(sample_b), .sample_vld(sample_vld_b),
    .busy(busy_b), .dsp_data(dsp_data_b), .dsp_vld(dsp_vld_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference formatting by decimal arithmetic.
  function automatic logic [31:0] fmt(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {4'hF, 16'hAAAA, (h != 0) ? h : 4'hA, ((h != 0) || (t != 0)) ? t : 4'hA, o};
  endfunction

  // Present one sample to instance a, then expect the update exactly 10 cycles later.
  task automatic conv_a(input logic [7:0] v, input logic [31:0] e, input string tag);
    sample_a = v;
    sample_vld_a = 1'b1;
    @(posedge clk); #1;
    sample_vld_a = 1'b0;
    check({tag, "_busy"}, 32'(busy_a), 32'd1);
    early = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k < 9) early = early | dsp_vld_a;
    end
    check({tag, "_early_vld"}, 32'(early), 32'd0);
    check({tag, "_vld"}, 32'(dsp_vld_a), 32'd1);
    check({tag, "_data"}, dsp_data_a, e);
    check({tag, "_idle"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    sample_a = '0; sample_vld_a = 1'b0;
    sample_b = '0; sample_vld_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_a", dsp_data_a, 32'hFAAA_AAAA);
    check("rst_data_b", dsp_data_b, 32'hFAAA_AAAA);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_vld_a", 32'(dsp_vld_a), 32'd0);
    rst = 1'b0;

    repeat (100) begin
      @(posedge clk); #1;
      check("idle_data_a", dsp_data_a, 32'hFAAA_AAAA);
      check("idle_vld_a", 32'(dsp_vld_a), 32'd0);
      check("idle_busy_a", 32'(busy_a), 32'd0);
      check("idle_data_b", dsp_data_b, 32'hFAAA_AAAA);
    end

    conv_a(8'd0,   32'hFAAA_AAA0, "v0");
    conv_a(8'd7,   32'hFAAA_AAA7, "v7");
    conv_a(8'd10,  32'hFAAA_AA10, "v10");
    conv_a(8'd99,  32'hFAAA_AA99, "v99");
    conv_a(8'd100, 32'hFAAA_A100, "v100");
    conv_a(8'd105, 32'hFAAA_A105, "v105");
    conv_a(8'd255, 32'hFAAA_A255, "v255");
    repeat (3) @(posedge clk);
    #1;
    check("hold_data_a", dsp_data_a, 32'hFAAA_A255);

    // Average of four: 100+101+102+104 = 407, >>2 = 101
    vec_b[0] = 8'd100; vec_b[1] = 8'd101; vec_b[2] = 8'd102; vec_b[3] = 8'd104;
    for (int i = 0; i < 4; i++) begin
      sample_b = vec_b[i];
      sample_vld_b = 1'b1;
      @(posedge clk); #1;
      check("avg_no_vld", 32'(dsp_vld_b), 32'd0);
      check("avg_busy", 32'(busy_b), (i == 3) ? 32'd1 : 32'd0);
    end
    sample_vld_b = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k < 9) early = early | dsp_vld_b;
    end
    check("avg_early_vld", 32'(early), 32'd0);
    check("avg_vld", 32'(dsp_vld_b), 32'd1);
    check("avg_data", dsp_data_b, 32'hFAAA_A101);

    // Samples offered while busy are dropped; the first one back in ACC is taken.
    sample_a = 8'd200;
    sample_vld_a = 1'b1;
    @(posedge clk); #1;
    sample_a = 8'd50;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
    end
    check("ovr_vld", 32'(dsp_vld_a), 32'd1);
    check("ovr_data", dsp_data_a, 32'hFAAA_A200);
    sample_a = 8'd77;
    @(posedge clk); #1;
    sample_vld_a = 1'b0;
    check("ovr_busy2", 32'(busy_a), 32'd1);
    repeat (9) @(posedge clk);
    #1;
    check("ovr2_vld", 32'(dsp_vld_a), 32'd1);
    check("ovr2_data", dsp_data_a, 32'hFAAA_AA77);

    // Reset during conversion (a) and mid-accumulation (b).
    sample_a = 8'd123; sample_vld_a = 1'b1;
    sample_b = 8'd255; sample_vld_b = 1'b1;
    @(posedge clk); #1;
    sample_vld_a = 1'b0;
    @(posedge clk); #1;
    sample_vld_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy_a), 32'd0);
    check("rst_mid_data", dsp_data_a, 32'hFAAA_AAAA);
    check("rst_mid_vld", 32'(dsp_vld_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    early = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      early = early | dsp_vld_a | dsp_vld_b;
    end
    check("rst_no_vld", 32'(early), 32'd0);
    check("rst_data_a2", dsp_data_a, 32'hFAAA_AAAA);
    conv_a(8'd42, 32'hFAAA_AA42, "v42");
    for (int i = 0; i < 4; i++) begin
      sample_b = 8'd4;
      sample_vld_b = 1'b1;
      @(posedge clk); #1;
    end
    sample_vld_b = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("rst_acc_vld", 32'(dsp_vld_b), 32'd1);
    check("rst_acc_data", dsp_data_b, 32'hFAAA_AAA4);
    repeat (2) @(posedge clk);
    #1;

    // Continuous valid with random data on both instances.
    hold_a = 0; hold_b = 0; due_a = -1; due_b = -1; acc_b = 0; n_b = 0;
    exp_a = '0; exp_b = '0;
    for (int c = 0; c < 1000; c++) begin
      s_a = 8'($urandom_range(0, 255));
      s_b = 8'($urandom_range(0, 255));
      sample_a = s_a; sample_vld_a = 1'b1;
      sample_b = s_b; sample_vld_b = 1'b1;
      @(posedge clk);
      if (due_a > 0) due_a--;
      if (due_b > 0) due_b--;
      #1;
      check("rnd_vld_a", 32'(dsp_vld_a), (due_a == 0) ? 32'd1 : 32'd0);
      check("rnd_vld_b", 32'(dsp_vld_b), (due_b == 0) ? 32'd1 : 32'd0);
      if (due_a == 0) begin
        check("rnd_data_a", dsp_data_a, exp_a);
        due_a = -1;
      end
      if (due_b == 0) begin
        check("rnd_data_b", dsp_data_b, exp_b);
        due_b = -1;
      end
      if (hold_a == 0) begin
        exp_a = fmt(int'(s_a));
        hold_a = 9;
        due_a = 9;
      end else begin
        hold_a--;
      end
      if (hold_b == 0) begin
        acc_b += int'(s_b);
        n_b++;
        if (n_b == 4) begin
          exp_b = fmt(acc_b / 4);
          acc_b = 0;
          n_b = 0;
          hold_b = 9;
          due_b = 9;
        end
      end else begin
        hold_b--;
      end
      check("rnd_busy_a", 32'(busy_a), (hold_a != 0) ? 32'd1 : 32'd0);
      check("rnd_busy_b", 32'(busy_b), (hold_b != 0) ? 32'd1 : 32'd0);
    end
    sample_vld_a = 1'b0;
    sample_vld_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
